// File: rtl/washing_machine_pkg.sv
// Shared state encoding, actuator bundle and per-state output decode
// for the washing machine sequencer.
package washing_machine_pkg;

    typedef enum logic [2:0] {
        IDLE          = 3'd0,
        CHECK_DOOR    = 3'd1,
        FILL_WATER    = 3'd2,
        ADD_DETERGENT = 3'd3,
        WASH          = 3'd4,
        DRAIN_WATER   = 3'd5,
        SPIN          = 3'd6,
        DONE          = 3'd7
    } wm_state_e;

    typedef struct packed {
        logic done;
        logic door_lock;
        logic fill_valve;
        logic drain_pump;
        logic spin_mode;
        logic motor;
    } wm_out_t;

    // With the door open mid-program only the lock stays engaged.
    function automatic wm_out_t decode_out(input wm_state_e s, input logic door);
        wm_out_t o;
        o = '0;
        case (s)
            FILL_WATER:    begin o.door_lock = 1'b1; o.fill_valve = door; end
            ADD_DETERGENT: o.door_lock = 1'b1;
            WASH:          begin o.door_lock = 1'b1; o.motor = door; end
            DRAIN_WATER:   begin o.door_lock = 1'b1; o.drain_pump = door; end
            SPIN:          begin o.door_lock = 1'b1; o.spin_mode = door; o.motor = door; end
            DONE:          o.done = 1'b1;
            default:       o = '0;
        endcase
        return o;
    endfunction

endpackage

// File: rtl/washing_machine.sv
// Moore sequencer: door check, fill, detergent, wash, drain, spin, done.
// Outputs are decoded from the next state and registered.
module washing_machine
    import washing_machine_pkg::*;
(
    input  logic clk,
    input  logic reset,
    input  logic start,
    input  logic door_close,
    input  logic filled_water,
    input  logic add_detergent,
    input  logic cycle,
    input  logic drain_water,
    input  logic spin,
    output logic done,
    output logic _door_close,
    output logic water_filled,
    output logic _water_drain,
    output logic _spin,
    output logic motor_on
);

    wm_state_e state, nxt;
    wm_out_t   out_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
            out_q <= '0;
        end else begin
            state <= nxt;
            out_q <= decode_out(nxt, door_close);
        end
    end

    // Mid-program states only advance while the door is closed.
    always_comb begin
        nxt = state;
        case (state)
            IDLE:          if (start) nxt = CHECK_DOOR;
            CHECK_DOOR:    if (door_close) nxt = FILL_WATER;
            FILL_WATER:    if (door_close && filled_water) nxt = ADD_DETERGENT;
            ADD_DETERGENT: if (door_close && add_detergent) nxt = WASH;
            WASH:          if (door_close && cycle) nxt = DRAIN_WATER;
            DRAIN_WATER:   if (door_close && drain_water) nxt = SPIN;
            SPIN:          if (door_close && spin) nxt = DONE;
            DONE:          if (!start) nxt = IDLE;
            default:       nxt = IDLE;
        endcase
    end

    assign done         = out_q.done;
    assign _door_close  = out_q.door_lock;
    assign water_filled = out_q.fill_valve;
    assign _water_drain = out_q.drain_pump;
    assign _spin        = out_q.spin_mode;
    assign motor_on     = out_q.motor;

endmodule

// File: tb/tb_washing_machine.sv
// Randomized bench for washing_machine against a step-table reference model.
module tb_washing_machine;

    logic clk = 1'b0;
    logic reset, start, door_close, filled_water, add_detergent, cycle, drain_water, spin;
    logic done, _door_close, water_filled, _water_drain, _spin, motor_on;

    int checks = 0;
    int errors = 0;
    int stage  = 0;           // 0 = idle ... 7 = finished
    logic [5:0] exp_o = '0;   // {done, lock, fill, drain, spin, motor}

    always #5 clk = ~clk;

    washing_machine dut (
        .clk(clk), .reset(reset), .start(start), .door_close(door_close),
        .filled_water(filled_water), .add_detergent(add_detergent), .cycle(cycle),
        .drain_water(drain_water), .spin(spin), .done(done), ._door_close(_door_close),
        .water_filled(water_filled), ._water_drain(_water_drain), ._spin(_spin),
        .motor_on(motor_on)
    );

    wire [5:0] dut_o = {done, _door_close, water_filled, _water_drain, _spin, motor_on};

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (stage %0d)", tag, got, exp, stage);
        end
    endtask

    function automatic logic [5:0] stage_out(input int st, input logic door);
        logic [5:0] o;
        case (st)
            2: o = 6'b011000;
            3: o = 6'b010000;
            4: o = 6'b010001;
            5: o = 6'b010100;
            6: o = 6'b010011;
            7: o = 6'b100000;
            default: o = 6'b000000;
        endcase
        if (st >= 2 && st <= 6 && !door) o = 6'b010000;
        return o;
    endfunction

    // Advance the model by one edge from the currently driven inputs.
    task automatic model_edge();
        logic [5:0] exits;
        exits = {spin, drain_water, cycle, add_detergent, filled_water, door_close};
        if (stage == 0) begin
            if (start) stage = 1;
        end else if (stage == 7) begin
            if (!start) stage = 0;
        end else if (stage == 1) begin
            if (door_close) stage = 2;
        end else if (door_close && exits[stage-1]) begin
            stage = stage + 1;
        end
        exp_o = stage_out(stage, door_close);
    endtask

    task automatic step(input string tag);
        @(posedge clk);
        model_edge();
        #1;
        check(tag, dut_o, exp_o);
        @(negedge clk);
    endtask

    task automatic set_in(input logic s, d, f, a, c, dr, sp);
        start = s; door_close = d; filled_water = f; add_detergent = a;
        cycle = c; drain_water = dr; spin = sp;
    endtask

    task automatic async_reset(input string tag);
        #2;
        reset = 1'b0;
        #1;
        check(tag, dut_o, 6'b0);
        stage = 0;
        exp_o = '0;
        @(posedge clk);
        #1;
        check({tag, "_hold"}, dut_o, 6'b0);
        @(negedge clk);
        reset = 1'b1;
    endtask

    initial begin
        reset = 1'b0;
        set_in(0, 0, 0, 0, 0, 0, 0);
        #12;
        check("reset_state", dut_o, 6'b0);
        @(negedge clk);
        reset = 1'b1;

        // All inputs high: done after exactly seven edges, held while start=1.
        set_in(1, 1, 1, 1, 1, 1, 1);
        for (int i = 1; i <= 7; i++) begin
            step("all_high");
            check("all_high_done", {31'b0, done}, (i == 7) ? 1 : 0);
        end
        for (int i = 0; i < 3; i++) step("done_hold");
        start = 1'b0;
        step("done_release");
        check("done_to_idle", stage, 0);

        // Door open at start.
        set_in(1, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 6; i++) step("door_open_check");
        check("stuck_check_door", stage, 1);
        door_close = 1'b1; start = 1'b0;
        step("door_closed_fill");
        check("fill_valve_on", {31'b0, water_filled}, 1);

        // Out-of-order exits in FILL have no effect.
        spin = 1'b1; drain_water = 1'b1;
        for (int i = 0; i < 3; i++) step("ooo_fill");
        check("ooo_still_fill", stage, 2);
        spin = 1'b0; drain_water = 1'b0; filled_water = 1'b1;
        step("fill_done");
        filled_water = 1'b0; add_detergent = 1'b1;
        step("to_wash");
        add_detergent = 1'b0;
        step("in_wash");

        // Door opened mid-WASH with cycle asserted.
        door_close = 1'b0; cycle = 1'b1;
        step("wash_door_open");
        check("wash_motor_off", {31'b0, motor_on}, 0);
        check("wash_lock_on", {31'b0, _door_close}, 1);
        step("wash_door_open2");
        door_close = 1'b1; cycle = 1'b0;
        step("wash_door_shut");
        check("wash_motor_back", {31'b0, motor_on}, 1);
        cycle = 1'b1;
        step("wash_to_drain");
        check("drain_pump_on", {31'b0, _water_drain}, 1);
        async_reset("rst_mid_drain");

        // Reach WASH again and abort.
        set_in(1, 1, 1, 1, 0, 0, 0);
        for (int i = 0; i < 5; i++) step("to_wash2");
        check("in_wash2", stage, 4);
        async_reset("rst_mid_wash");

        // Randomized run.
        for (int n = 0; n < 3000; n++) begin
            set_in($urandom_range(0, 99) < 70, $urandom_range(0, 99) < 85,
                   1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom));
            if ($urandom_range(0, 199) == 0) async_reset("rand_rst");
            else step("rand");
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
